mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access stage of the 16-bit RISC pipeline, sitting directly downstream of the execute stage and consuming its ALU result, branch adder result, Zero flag and selected destination register. It holds the EX/MEM pipeline register and drives the data-memory request/acknowledge handshake for loads and stores, stalling execute while an access is outstanding. It resolves branches toward fetch and presents a write-back bundle to the register file.

## Interface
- DATA_W, 16, data and address width
- TIMEOUT_CYCLES, 64, ACCESS cycles without dmem_ack before abort (used only with watchdog compiled in)

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  execute presents a valid instruction
- ex_ready  out  1  stage accepts this cycle; 1 iff state is IDLE
- alu_result  in  DATA_W  ALU result; memory address for loads/stores
- adder_result  in  DATA_W  branch target
- zero  in  1  ALU Zero flag
- write_reg  in  3  destination register (rd/rt already selected)
- store_data  in  DATA_W  register operand 2, data for stores
- branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in  in  1 each  control bits
- dmem_req  out  1  memory request, held until acknowledged
- dmem_we  out  1  1 = store
- dmem_addr  out  DATA_W  access address
- dmem_wdata  out  DATA_W  store data
- dmem_ack  in  1  one-cycle completion strobe
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- pc_src  out  1  one-cycle taken-branch pulse
- branch_target  out  DATA_W  target, valid while pc_src = 1
- wb_valid  out  1  one-cycle write-back strobe
- wb_reg_write  out  1  register-file write enable, qualified by wb_valid
- wb_write_reg  out  3  destination register
- wb_data  out  DATA_W  mem_to_reg ? loaded data : alu_result
- mem_err  out  1  one-cycle access-timeout pulse

## Operation
- States: IDLE, ACCESS.
- Capture: ex_valid & ex_ready latches all inputs into the EX/MEM register.
- Non-memory op captured at edge N: wb_valid = 1 for cycle N+1; remain in IDLE. Back-to-back capture allowed every cycle.
- Memory op (mem_read_in or mem_write_in) captured at edge N: enter ACCESS at N+1 with dmem_req = 1 and dmem_addr, dmem_wdata, dmem_we stable; ex_ready = 0.
- dmem_ack sampled high in ACCESS at edge M: load latches dmem_rdata; return to IDLE; wb_valid = 1 in cycle M+1. ex_ready returns to 1 in cycle M+1.
- Store: wb_reg_write forced 0 regardless of reg_write_in.
- mem_read_in and mem_write_in both set: handled as a store; no data latched.
- Branch: branch_in & zero at capture edge N: pc_src = 1 and branch_target = adder_result in cycle N+1. Branch with zero = 0: no pulse.
- dmem_ack in IDLE: ignored.
- Reset: state IDLE; dmem_req, dmem_we, pc_src, wb_valid, wb_reg_write, mem_err = 0; all data registers = 0. Reset during ACCESS abandons the access; dmem_req is low from the first post-reset cycle.

## Timing
- ALU op latency: 1 cycle capture to wb_valid.
- Memory op latency: 1 + k + 1 cycles, where k ≥ 1 is the number of ACCESS cycles up to and including the dmem_ack cycle.
- All outputs are registered except ex_ready (decoded from state).
- dmem_req never deasserts before dmem_ack except on reset or timeout.

## Configuration
- MEM_TIMEOUT_EN defined: a counter runs in ACCESS. If TIMEOUT_CYCLES cycles elapse with no dmem_ack:
  - dmem_req drops and state returns to IDLE.
  - mem_err pulses 1 cycle, coincident with wb_valid = 1 and wb_reg_write = 0.
- MEM_TIMEOUT_EN undefined: ACCESS waits indefinitely. mem_err is tied 0; the port remains present.

## Structure
- Shared package risc_pkg holds:
  - DATA_W and REG_ADDR_W = 3
  - the state enum {IDLE, ACCESS}
  - a packed ex_mem_t struct bundling the captured fields.
- Optional sub-module mem_watchdog (counter plus expiry flag) is instantiated only under MEM_TIMEOUT_EN.

## Test plan
- ALU op: alu_result = 0x1234, write_reg = 3, reg_write_in = 1 -> next cycle wb_valid = 1, wb_data = 0x1234, wb_write_reg = 3.
- Load at address 0x0040, dmem_ack after 3 cycles with rdata 0xBEEF:
  - dmem_req high 3 cycles, ex_ready low throughout.
  - wb_data = 0xBEEF one cycle after ack.
- Store of 0x00AA to address 0x0010 with reg_write_in = 1 -> dmem_we = 1, dmem_wdata = 0x00AA, then wb_valid = 1 with wb_reg_write = 0.
- Branch: branch_in = 1, zero = 1, adder_result = 0x0022 -> pc_src pulses 1 with branch_target = 0x0022. Repeat with zero = 0 -> no pulse.
- rst asserted during ACCESS -> next cycle dmem_req = 0, ex_ready = 1, wb_valid = 0. A late dmem_ack is ignored.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES = 4 and no ack -> after 4 ACCESS cycles, mem_err = 1 and wb_reg_write = 0.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC pipeline slice.
// Contents:
//   DATA_W      data/address width
//   REG_ADDR_W  register-file address width
//   state_t     memory-access stage controller states
//   ex_mem_t    EX/MEM pipeline register fields that outlive the capture edge
//   is_load()   classifies a captured op as a pure load
package risc_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Only the fields still needed after capture are kept; branch resolution
  // happens on the capture edge itself, so branch/zero/target are not stored.
  typedef struct packed {
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     store_data;
    logic [REG_ADDR_W-1:0] write_reg;
    logic                  mem_read;
    logic                  mem_write;
    logic                  reg_write;
    logic                  mem_to_reg;
  } ex_mem_t;

  // An op with both read and write set is treated as a store, so it is
  // never a load.
  function automatic logic is_load(input ex_mem_t f);
    return f.mem_read & ~f.mem_write;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Data-memory request/acknowledge bus.
// Signals:
//   req    request, held until acknowledged
//   we     1 = store
//   addr   access address
//   wdata  store data
//   ack    one-cycle completion strobe
//   rdata  load data, valid with ack
// Modports: master (pipeline stage), slave (memory).
interface dmem_if #(
  parameter int DATA_W = 16
) ();

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_watchdog.sv
// Access watchdog: counts cycles while run is high and flags expiry on the
// TIMEOUT_CYCLES-th consecutive cycle. Used only when MEM_TIMEOUT_EN is
// defined.
// Ports:
//   clk      clock
//   rst      synchronous active-high reset
//   run      high while the stage is waiting for a memory acknowledge
//   expired  high during the last permitted wait cycle
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  import risc_pkg::*;

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_r;

  // cnt_r holds the number of wait cycles already completed.
  assign expired = run & (cnt_r == LAST_CNT);

  // Wait-cycle counter, cleared whenever the stage is not waiting.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= CNT_W'(0);
    end else if (!run) begin
      cnt_r <= CNT_W'(0);
    end else if (!expired) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage of the 16-bit RISC pipeline. Holds the EX/MEM register,
// runs the data-memory handshake for loads/stores (stalling execute while an
// access is outstanding), resolves branches and presents a write-back bundle.
// Optional feature: MEM_TIMEOUT_EN adds an access watchdog that aborts an
// access after TIMEOUT_CYCLES wait cycles and pulses mem_err.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_valid / ex_ready       execute handshake (ex_ready = state is IDLE)
//   alu_result, adder_result, zero, write_reg, store_data   execute results
//   branch_in .. mem_to_reg_in  control bits
//   dmem                      data-memory bus (master side)
//   pc_src, branch_target     taken-branch pulse and target
//   wb_valid, wb_reg_write, wb_write_reg, wb_data  write-back bundle
//   mem_err                   access-timeout pulse (0 without MEM_TIMEOUT_EN)
module mem_access_stage #(
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ex_valid,
  output logic                            ex_ready,
  input  logic [DATA_W-1:0]               alu_result,
  input  logic [DATA_W-1:0]               adder_result,
  input  logic                            zero,
  input  logic [risc_pkg::REG_ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0]               store_data,
  input  logic                            branch_in,
  input  logic                            mem_read_in,
  input  logic                            mem_write_in,
  input  logic                            reg_write_in,
  input  logic                            mem_to_reg_in,
  dmem_if.master                          dmem,
  output logic                            pc_src,
  output logic [DATA_W-1:0]               branch_target,
  output logic                            wb_valid,
  output logic                            wb_reg_write,
  output logic [risc_pkg::REG_ADDR_W-1:0] wb_write_reg,
  output logic [DATA_W-1:0]               wb_data,
  output logic                            mem_err
);

  import risc_pkg::*;

  state_t                state_r;
  state_t                state_n;
  ex_mem_t               ex_mem_r;
  logic [DATA_W-1:0]     load_data_r;

  logic                  capture_s;
  logic                  is_mem_s;
  logic                  access_s;
  logic                  timeout_s;

  logic                  pc_src_r,       pc_src_n;
  logic [DATA_W-1:0]     branch_target_r, branch_target_n;
  logic                  wb_valid_r,     wb_valid_n;
  logic                  wb_reg_write_r, wb_reg_write_n;
  logic [REG_ADDR_W-1:0] wb_write_reg_r, wb_write_reg_n;
  logic [DATA_W-1:0]     wb_data_r,      wb_data_n;
  logic                  dmem_req_r,     dmem_req_n;

  assign access_s  = (state_r == ACCESS);
  assign ex_ready  = (state_r == IDLE);
  assign capture_s = ex_valid & ex_ready;
  assign is_mem_s  = mem_read_in | mem_write_in;

`ifdef MEM_TIMEOUT_EN
  logic expired_s;
  logic mem_err_r, mem_err_n;

  mem_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .run     (access_s),
    .expired (expired_s)
  );

  // An acknowledge arriving in the final wait cycle still completes normally.
  assign timeout_s = expired_s & ~dmem.ack;
  assign mem_err   = mem_err_r;
`else
  assign timeout_s = 1'b0;
  assign mem_err   = 1'b0;
`endif

  // Address, data and direction come straight from the EX/MEM register, which
  // cannot change while an access is outstanding (ex_ready is low).
  assign dmem.req      = dmem_req_r;
  assign dmem.we       = ex_mem_r.mem_write;
  assign dmem.addr     = ex_mem_r.alu_result;
  assign dmem.wdata    = ex_mem_r.store_data;

  assign pc_src        = pc_src_r;
  assign branch_target = branch_target_r;
  assign wb_valid      = wb_valid_r;
  assign wb_reg_write  = wb_reg_write_r;
  assign wb_write_reg  = wb_write_reg_r;
  assign wb_data       = wb_data_r;

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Controller next-state decode.
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s && is_mem_s) begin
          state_n = ACCESS;
        end else begin
          state_n = IDLE;
        end
      end
      ACCESS: begin
        if (dmem.ack || timeout_s) begin
          state_n = IDLE;
        end else begin
          state_n = ACCESS;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    pc_src_n        = 1'b0;
    branch_target_n = branch_target_r;
    wb_valid_n      = 1'b0;
    wb_reg_write_n  = 1'b0;
    wb_write_reg_n  = wb_write_reg_r;
    wb_data_n       = wb_data_r;
    dmem_req_n      = 1'b0;
`ifdef MEM_TIMEOUT_EN
    mem_err_n       = 1'b0;
`endif
    case (state_r)
      IDLE: begin
        if (capture_s) begin
          if (branch_in && zero) begin
            pc_src_n        = 1'b1;
            branch_target_n = adder_result;
          end else begin
            pc_src_n        = 1'b0;
          end
          if (is_mem_s) begin
            dmem_req_n      = 1'b1;
          end else begin
            wb_valid_n      = 1'b1;
            wb_reg_write_n  = reg_write_in;
            wb_write_reg_n  = write_reg;
            wb_data_n       = mem_to_reg_in ? load_data_r : alu_result;
          end
        end else begin
          dmem_req_n        = 1'b0;
        end
      end
      ACCESS: begin
        if (dmem.ack) begin
          wb_valid_n        = 1'b1;
          // Stores never write the register file.
          wb_reg_write_n    = ex_mem_r.reg_write & ~ex_mem_r.mem_write;
          wb_write_reg_n    = ex_mem_r.write_reg;
          if (ex_mem_r.mem_to_reg) begin
            wb_data_n       = is_load(ex_mem_r) ? dmem.rdata : load_data_r;
          end else begin
            wb_data_n       = ex_mem_r.alu_result;
          end
        end else if (timeout_s) begin
          wb_valid_n        = 1'b1;
          wb_reg_write_n    = 1'b0;
          wb_write_reg_n    = ex_mem_r.write_reg;
          wb_data_n         = ex_mem_r.alu_result;
`ifdef MEM_TIMEOUT_EN
          mem_err_n         = 1'b1;
`endif
        end else begin
          dmem_req_n        = 1'b1;
        end
      end
      default: begin
        dmem_req_n          = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_src_r        <= 1'b0;
      branch_target_r <= {DATA_W{1'b0}};
      wb_valid_r      <= 1'b0;
      wb_reg_write_r  <= 1'b0;
      wb_write_reg_r  <= {REG_ADDR_W{1'b0}};
      wb_data_r       <= {DATA_W{1'b0}};
      dmem_req_r      <= 1'b0;
    end else begin
      pc_src_r        <= pc_src_n;
      branch_target_r <= branch_target_n;
      wb_valid_r      <= wb_valid_n;
      wb_reg_write_r  <= wb_reg_write_n;
      wb_write_reg_r  <= wb_write_reg_n;
      wb_data_r       <= wb_data_n;
      dmem_req_r      <= dmem_req_n;
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Timeout error pulse register.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err_r <= 1'b0;
    end else begin
      mem_err_r <= mem_err_n;
    end
  end
`endif

  // EX/MEM pipeline register, loaded on every accepted instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mem_r <= '0;
    end else if (capture_s) begin
      ex_mem_r.alu_result <= alu_result;
      ex_mem_r.store_data <= store_data;
      ex_mem_r.write_reg  <= write_reg;
      ex_mem_r.mem_read   <= mem_read_in;
      ex_mem_r.mem_write  <= mem_write_in;
      ex_mem_r.reg_write  <= reg_write_in;
      ex_mem_r.mem_to_reg <= mem_to_reg_in;
    end else begin
      ex_mem_r <= ex_mem_r;
    end
  end

  // Most recent load data, kept for mem_to_reg selection.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_data_r <= {DATA_W{1'b0}};
    end else if (access_s && dmem.ack && is_load(ex_mem_r)) begin
      load_data_r <= dmem.rdata;
    end else begin
      load_data_r <= load_data_r;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios followed by a
// randomized mix of ALU ops, loads, stores and idle cycles. Expected values
// come from a transaction-level model (last loaded value plus per-op rules).
// Define MEM_TIMEOUT_EN to also exercise the access watchdog.
module tb_mem_access_stage;

  localparam int DW = 16;
  localparam int TO = 4;
`ifdef MEM_TIMEOUT_EN
  localparam int KMAX = TO - 1;
`else
  localparam int KMAX = 6;
`endif

  logic          clk;
  logic          rst;
  logic          ex_valid;
  logic          ex_ready;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] adder_result;
  logic          zero;
  logic [2:0]    write_reg;
  logic [DW-1:0] store_data;
  logic          branch_in, mem_read_in, mem_write_in, reg_write_in, mem_to_reg_in;
  logic          pc_src;
  logic [DW-1:0] branch_target;
  logic          wb_valid, wb_reg_write;
  logic [2:0]    wb_write_reg;
  logic [DW-1:0] wb_data;
  logic          mem_err;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] last_load;

  dmem_if #(.DATA_W(DW)) dmem ();

  mem_access_stage #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .alu_result(alu_result), .adder_result(adder_result), .zero(zero),
    .write_reg(write_reg), .store_data(store_data), .branch_in(branch_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .dmem(dmem), .pc_src(pc_src), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_data(wb_data), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] adder,
                       input logic z, input logic [2:0] wr, input logic [DW-1:0] sd,
                       input logic br, input logic mr, input logic mw, input logic rw,
                       input logic m2r);
    ex_valid = v; alu_result = alu; adder_result = adder; zero = z; write_reg = wr;
    store_data = sd; branch_in = br; mem_read_in = mr; mem_write_in = mw;
    reg_write_in = rw; mem_to_reg_in = m2r;
  endtask

  task automatic drive_junk();
    drive(1'b1, DW'($urandom), DW'($urandom), 1'($urandom), 3'($urandom), DW'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Non-memory op: write-back and branch resolution one cycle after capture.
  task automatic do_alu(input logic [DW-1:0] alu, input logic [DW-1:0] adder, input logic z,
                        input logic [2:0] wr, input logic br, input logic rw, input logic m2r);
    drive(1'b1, alu, adder, z, wr, DW'($urandom), br, 1'b0, 1'b0, rw, m2r);
    tick();
    ex_valid = 1'b0;
    check("alu_wb_valid", 32'(wb_valid), 32'd1);
    check("alu_wb_reg_write", 32'(wb_reg_write), 32'(rw));
    check("alu_wb_write_reg", 32'(wb_write_reg), 32'(wr));
    check("alu_wb_data", 32'(wb_data), m2r ? 32'(last_load) : 32'(alu));
    check("alu_pc_src", 32'(pc_src), 32'(br & z));
    if (br & z) check("alu_branch_target", 32'(branch_target), 32'(adder));
    check("alu_ex_ready", 32'(ex_ready), 32'd1);
    check("alu_dmem_req", 32'(dmem.req), 32'd0);
    check("alu_mem_err", 32'(mem_err), 32'd0);
  endtask

  // Memory op acknowledged in its k-th wait cycle.
  task automatic do_mem(input logic [DW-1:0] addr, input logic [DW-1:0] sd, input logic [2:0] wr,
                        input logic mr, input logic mw, input logic rw, input logic m2r,
                        input logic br, input logic z, input logic [DW-1:0] adder,
                        input int k, input logic [DW-1:0] rdata);
    drive(1'b1, addr, adder, z, wr, sd, br, mr, mw, rw, m2r);
    tick();
    for (int i = 1; i <= k; i++) begin
      check("mem_req", 32'(dmem.req), 32'd1);
      check("mem_ex_ready", 32'(ex_ready), 32'd0);
      check("mem_addr", 32'(dmem.addr), 32'(addr));
      check("mem_we", 32'(dmem.we), 32'(mw));
      if (mw) check("mem_wdata", 32'(dmem.wdata), 32'(sd));
      check("mem_wb_valid", 32'(wb_valid), 32'd0);
      check("mem_pc_src", 32'(pc_src), (i == 1) ? 32'(br & z) : 32'd0);
      if (i == 1 && (br & z)) check("mem_branch_target", 32'(branch_target), 32'(adder));
      drive_junk();
      dmem.ack   = (i == k);
      dmem.rdata = (i == k) ? rdata : DW'($urandom);
      tick();
    end
    dmem.ack = 1'b0;
    ex_valid = 1'b0;
    if (mr && !mw) last_load = rdata;
    check("mem_done_wb_valid", 32'(wb_valid), 32'd1);
    check("mem_done_wb_reg_write", 32'(wb_reg_write), 32'(rw & ~mw));
    check("mem_done_wb_write_reg", 32'(wb_write_reg), 32'(wr));
    check("mem_done_wb_data", 32'(wb_data), m2r ? 32'(last_load) : 32'(addr));
    check("mem_done_req", 32'(dmem.req), 32'd0);
    check("mem_done_ex_ready", 32'(ex_ready), 32'd1);
    check("mem_done_mem_err", 32'(mem_err), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    dmem.ack = 1'b0;
    dmem.rdata = '0;
    drive(1'b0, '0, '0, 1'b0, 3'd0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    last_load = '0;
    tick();
    tick();
    check("rst_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_dmem_req", 32'(dmem.req), 32'd0);
    check("rst_dmem_we", 32'(dmem.we), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_pc_src", 32'(pc_src), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_mem_err", 32'(mem_err), 32'd0);
    rst = 1'b0;
    tick();

    // ALU op
    do_alu(16'h1234, 16'h0000, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0);
    // Load at 0x0040, ack in third wait cycle
    do_mem(16'h0040, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 3, 16'hBEEF);
    // Store 0x00AA to 0x0010 with reg_write_in set
    do_mem(16'h0010, 16'h00AA, 3'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 2, 16'h1111);
    // Branch taken, then not taken
    do_alu(16'h0000, 16'h0022, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    do_alu(16'h0001, 16'h0044, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0);
    // Back-to-back ALU ops, one selecting the last loaded value
    do_alu(16'h0AB0, 16'h0, 1'b0, 3'd7, 1'b0, 1'b1, 1'b0);
    do_alu(16'h0AB1, 16'h0, 1'b0, 3'd6, 1'b0, 1'b1, 1'b1);
    // Acknowledge while idle is ignored
    dmem.ack = 1'b1;
    dmem.rdata = 16'h7777;
    tick();
    dmem.ack = 1'b0;
    check("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
    check("idle_ack_req", 32'(dmem.req), 32'd0);
    check("idle_ack_ex_ready", 32'(ex_ready), 32'd1);
    // Read and write both set: store, nothing latched
    do_mem(16'h0020, 16'h5A5A, 3'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1, 16'hC0DE);
    // Reset during an access abandons it
    drive(1'b1, 16'h0080, 16'h0, 1'b0, 3'd1, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check("rst_acc_req_before", 32'(dmem.req), 32'd1);
    ex_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    last_load = '0;
    check("rst_acc_req", 32'(dmem.req), 32'd0);
    check("rst_acc_ex_ready", 32'(ex_ready), 32'd1);
    check("rst_acc_wb_valid", 32'(wb_valid), 32'd0);
    dmem.ack = 1'b1;
    dmem.rdata = 16'h9999;
    tick();
    dmem.ack = 1'b0;
    check("late_ack_wb_valid", 32'(wb_valid), 32'd0);
    check("late_ack_req", 32'(dmem.req), 32'd0);
    do_alu(16'h0000, 16'h0, 1'b0, 3'd2, 1'b0, 1'b1, 1'b1);

`ifdef MEM_TIMEOUT_EN
    // No acknowledge: abort after TO wait cycles
    drive(1'b1, 16'h0300, 16'h0, 1'b0, 3'd3, 16'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < TO; i++) begin
      check("to_req", 32'(dmem.req), 32'd1);
      check("to_mem_err_low", 32'(mem_err), 32'd0);
      tick();
    end
    check("to_mem_err", 32'(mem_err), 32'd1);
    check("to_wb_valid", 32'(wb_valid), 32'd1);
    check("to_wb_reg_write", 32'(wb_reg_write), 32'd0);
    check("to_req_drop", 32'(dmem.req), 32'd0);
    check("to_ex_ready", 32'(ex_ready), 32'd1);
    tick();
    check("to_mem_err_pulse", 32'(mem_err), 32'd0);
    check("to_wb_valid_pulse", 32'(wb_valid), 32'd0);
`endif

    // Randomized mix
    for (int n = 0; n < 120; n++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel < 2) begin
        dmem.ack = 1'($urandom);
        tick();
        dmem.ack = 1'b0;
        check("rnd_idle_wb_valid", 32'(wb_valid), 32'd0);
        check("rnd_idle_pc_src", 32'(pc_src), 32'd0);
        check("rnd_idle_req", 32'(dmem.req), 32'd0);
      end else if (sel < 6) begin
        do_alu(DW'($urandom), DW'($urandom), 1'($urandom), 3'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom));
      end else begin
        logic mr, mw;
        int kind;
        kind = int'($urandom_range(0, 2));
        mr = (kind != 1);
        mw = (kind != 0);
        do_mem(DW'($urandom), DW'($urandom), 3'($urandom), mr, mw, 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), DW'($urandom),
               int'($urandom_range(1, KMAX)), DW'($urandom));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
